udp_sweep_controller: RTL and testbench

- Sequencer for the 3-input function circuit (e = f(a,b,c), f = e & d) with expected minterm mask Sum(0,2,4,6,7).
- Drives a, b, c and d through all 16 input combinations, waits a settle time, samples e and f, and compares each sample with the expected value.
- Builds truth-table signatures and reports pass/fail with a start/busy/done handshake.
- Used as the on-chip self-check that sits in front of a combinational function block.

---
 rtl/udp_sweep_controller_if.sv | 26 ++
 rtl/udp_sweep_controller.sv | 121 ++++++++++++
 tb/tb_udp_sweep_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_sweep_controller_if.sv
// rtl/udp_sweep_controller_if.sv - handshake, drive and result bundle of the sweep controller
interface udp_sweep_controller_if;
  logic       start;
  logic       abort;
  logic [2:0] abc_o;
  logic       d_o;
  logic       e_i;
  logic       f_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] e_sig;
  logic [7:0] f_sig;
  logic       err_valid;
  logic [3:0] err_idx;

  modport slave (
    input  start, abort, e_i, f_i,
    output abc_o, d_o, busy, done, pass, e_sig, f_sig, err_valid, err_idx
  );

  modport master (
    output start, abort, e_i, f_i,
    input  abc_o, d_o, busy, done, pass, e_sig, f_sig, err_valid, err_idx
  );
endinterface

// File: rtl/udp_sweep_controller.sv
// rtl/udp_sweep_controller.sv - exhaustive 16-point self-check sequencer for e=f(a,b,c), f=e&d
module udp_sweep_controller #(
  parameter logic [7:0] EXP_MASK = 8'hD5,
  parameter int         SETTLE   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  udp_sweep_controller_if.slave  bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_abc;
  logic          r_d;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [7:0]    r_e_sig;
  logic [7:0]    r_f_sig;
  logic          r_err_valid;
  logic [3:0]    r_err_idx;

  logic w_exp_e;
  logic w_exp_f;
  logic w_mism;

  assign w_exp_e = EXP_MASK[r_idx[2:0]];
  assign w_exp_f = r_idx[3] & w_exp_e;
  assign w_mism  = (bus.e_i != w_exp_e) || (bus.f_i != w_exp_f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_cnt       <= '0;
      r_abc       <= 3'd0;
      r_d         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_e_sig     <= 8'd0;
      r_f_sig     <= 8'd0;
      r_err_valid <= 1'b0;
      r_err_idx   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_e_sig     <= 8'd0;
            r_f_sig     <= 8'd0;
            r_err_valid <= 1'b0;
            r_err_idx   <= 4'd0;
            r_pass      <= 1'b0;
            r_idx       <= 4'd0;
            r_busy      <= 1'b1;
            r_state     <= S_DRIVE;
          end
        end
        S_DRIVE, S_WAIT, S_SAMPLE: begin
          // Abort leaves the partial signatures and error record for inspection.
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_abc   <= 3'd0;
            r_d     <= 1'b0;
          end else if (r_state == S_DRIVE) begin
            r_abc   <= r_idx[2:0];
            r_d     <= r_idx[3];
            r_cnt   <= SETTLE_V;
            r_state <= (SETTLE > 0) ? S_WAIT : S_SAMPLE;
          end else if (r_state == S_WAIT) begin
            if (r_cnt <= CW'(1)) r_state <= S_SAMPLE;
            else                 r_cnt   <= r_cnt - CW'(1);
          end else begin
            if (!r_idx[3]) r_e_sig[r_idx[2:0]] <= bus.e_i;
            else           r_f_sig[r_idx[2:0]] <= bus.f_i;
            if (w_mism && !r_err_valid) begin
              r_err_valid <= 1'b1;
              r_err_idx   <= r_idx;
            end
            if (r_idx == 4'd15) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= ~(r_err_valid | w_mism);
              r_abc   <= 3'd0;
              r_d     <= 1'b0;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_DRIVE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.abc_o     = r_abc;
  assign bus.d_o       = r_d;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.e_sig     = r_e_sig;
  assign bus.f_sig     = r_f_sig;
  assign bus.err_valid = r_err_valid;
  assign bus.err_idx   = r_err_idx;

endmodule

// File: tb/tb_udp_sweep_controller.sv
// tb/tb_udp_sweep_controller.sv - randomized self-check of udp_sweep_controller against a truth-table model
module tb_udp_sweep_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  udp_sweep_controller_if if1();
  udp_sweep_controller_if if0();

  udp_sweep_controller #(.EXP_MASK(8'hD5), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  udp_sweep_controller #(.EXP_MASK(8'hD5), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  // Circuit under test: e looked up by {a,b,c}, f by {d,a,b,c}.
  logic [7:0]  circ_e;
  logic [15:0] circ_f;
  always_comb begin
    if1.e_i = circ_e[if1.abc_o];
    if1.f_i = circ_f[{if1.d_o, if1.abc_o}];
    if0.e_i = circ_e[if0.abc_o];
    if0.f_i = circ_f[{if0.d_o, if0.abc_o}];
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] m_esig, m_fsig;
  logic       m_err, m_pass;
  logic [3:0] m_idx;

  task automatic model();
    logic [7:0] spec_mask;
    logic [3:0] i4;
    logic ee, ff, xe, xf;
    spec_mask = 8'hD5;
    m_esig = 0; m_fsig = 0; m_err = 0; m_idx = 0;
    for (int i = 0; i < 16; i++) begin
      i4 = i[3:0];
      ee = circ_e[i4[2:0]];
      ff = circ_f[i4];
      xe = spec_mask[i4[2:0]];
      xf = i4[3] & xe;
      if (!i4[3]) m_esig[i4[2:0]] = ee;
      else        m_fsig[i4[2:0]] = ff;
      if (((ee != xe) || (ff != xf)) && !m_err) begin
        m_err = 1'b1;
        m_idx = i4;
      end
    end
    m_pass = !m_err;
  endtask

  task automatic sweep1(input bit repulse, output int done_cyc, output int busy_cyc);
    int cyc;
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    cyc = 1; busy_cyc = 0; done_cyc = 0;
    while (cyc < 200 && done_cyc == 0) begin
      if (if1.busy) busy_cyc++;
      if (if1.done) done_cyc = cyc;
      if1.start = repulse && (cyc == 5 || cyc == 30);
      @(negedge clk);
      cyc++;
    end
    if1.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if1.start = 0; if1.abort = 0; if0.start = 0; if0.abort = 0;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    repeat (2) @(negedge clk);
    n_total++;
    if ({if1.abc_o, if1.d_o, if1.busy, if1.done, if1.pass, if1.e_sig, if1.f_sig, if1.err_valid, if1.err_idx} !== '0) begin
      $display("FAIL reset_outputs: got e_sig=%h f_sig=%h busy=%b pass=%b err=%b idx=%h, want all 0",
               if1.e_sig, if1.f_sig, if1.busy, if1.pass, if1.err_valid, if1.err_idx);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct();
    int dc, bc;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    sweep1(0, dc, bc);
    n_total++; if (dc !== 49) $display("FAIL correct_done_cycle: got %0d want 49", dc); else n_pass++;
    n_total++; if (bc !== 48) $display("FAIL correct_busy_cycles: got %0d want 48", bc); else n_pass++;
    n_total++;
    if ({if1.pass, if1.e_sig, if1.f_sig, if1.err_valid} !== {1'b1, 8'hD5, 8'hD5, 1'b0})
      $display("FAIL correct_result: got pass=%b e=%h f=%h err=%b want 1 d5 d5 0", if1.pass, if1.e_sig, if1.f_sig, if1.err_valid);
    else n_pass++;
  endtask

  task automatic test_fault_e();
    int dc, bc;
    circ_e = 8'hF5; circ_f = {8'hD5, 8'h00};
    sweep1(0, dc, bc);
    n_total++;
    if ({if1.e_sig, if1.err_valid, if1.err_idx, if1.pass} !== {8'hF5, 1'b1, 4'd5, 1'b0})
      $display("FAIL fault_e: got e=%h err=%b idx=%0d pass=%b want f5 1 5 0", if1.e_sig, if1.err_valid, if1.err_idx, if1.pass);
    else n_pass++;
  endtask

  task automatic test_f_tied();
    int dc, bc;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'hD5};
    sweep1(0, dc, bc);
    n_total++;
    if ({if1.err_idx, if1.f_sig, if1.pass, if1.err_valid} !== {4'd0, 8'hD5, 1'b0, 1'b1})
      $display("FAIL f_tied: got idx=%0d f=%h pass=%b err=%b want 0 d5 0 1", if1.err_idx, if1.f_sig, if1.pass, if1.err_valid);
    else n_pass++;
  endtask

  task automatic test_abort();
    int dc, bc, seen;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    repeat (19) @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk) if1.abort = 1'b0;
    n_total++;
    if ({if1.busy, if1.done, if1.pass, if1.abc_o, if1.d_o} !== 6'd0)
      $display("FAIL abort_state: got busy=%b done=%b pass=%b abc=%0d d=%b want all 0",
               if1.busy, if1.done, if1.pass, if1.abc_o, if1.d_o);
    else n_pass++;
    seen = 0;
    repeat (60) begin @(negedge clk); if (if1.done || if1.busy) seen++; end
    n_total++; if (seen !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", seen); else n_pass++;
    sweep1(0, dc, bc);
    n_total++;
    if ({dc, if1.pass} !== {32'd49, 1'b1}) $display("FAIL abort_restart: got done=%0d pass=%b want 49 1", dc, if1.pass);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, bc, seen;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    sweep1(1, dc, bc);
    n_total++; if (dc !== 49) $display("FAIL repulse_done_cycle: got %0d want 49", dc); else n_pass++;
    @(negedge clk) begin if1.start = 1'b1; if1.abort = 1'b1; end
    @(negedge clk) begin if1.start = 1'b0; if1.abort = 1'b0; end
    seen = 0;
    repeat (5) begin if (if1.busy) seen++; @(negedge clk); end
    n_total++; if (seen !== 0) $display("FAIL start_abort_idle: busy seen %0d cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    repeat (24) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({if1.abc_o, if1.d_o, if1.busy, if1.done, if1.pass, if1.e_sig, if1.f_sig, if1.err_valid, if1.err_idx} !== '0)
      $display("FAIL reset_mid: got busy=%b e=%h f=%h abc=%0d want all 0", if1.busy, if1.e_sig, if1.f_sig, if1.abc_o);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_settle0();
    int cyc, dc;
    circ_e = 8'hD5; circ_f = {8'hD5, 8'h00};
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    cyc = 1; dc = 0;
    while (cyc < 200 && dc == 0) begin
      if (if0.done) dc = cyc;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if ({dc, if0.pass, if0.e_sig} !== {32'd33, 1'b1, 8'hD5})
      $display("FAIL settle0: got done=%0d pass=%b e=%h want 33 1 d5", dc, if0.pass, if0.e_sig);
    else n_pass++;
  endtask

  task automatic test_random();
    int dc, bc;
    for (int it = 0; it < 8; it++) begin
      circ_e = ($urandom_range(0, 1) == 0) ? 8'hD5 : 8'($urandom);
      circ_f = ($urandom_range(0, 1) == 0) ? {circ_e, 8'h00} : 16'($urandom);
      model();
      sweep1(0, dc, bc);
      n_total++;
      if ({dc, if1.e_sig, if1.f_sig, if1.err_valid, if1.err_idx, if1.pass} !== {32'd49, m_esig, m_fsig, m_err, m_idx, m_pass})
        $display("FAIL random_%0d: got done=%0d e=%h f=%h err=%b idx=%0d pass=%b want 49 %h %h %b %0d %b",
                 it, dc, if1.e_sig, if1.f_sig, if1.err_valid, if1.err_idx, if1.pass, m_esig, m_fsig, m_err, m_idx, m_pass);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_fault_e();
    test_f_tied();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_settle0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
